// File: rtl/max_frame_arbiter.sv
// max_frame_arbiter
//
// Shares a single find_max engine among N stream requesters, one frame at a
// time. An idle arbiter picks a winner among the requesters with s_valid
// high. It streams the winner's frame into the engine and captures the
// engine's max on done. It then returns {max, requester id} over a
// valid/ready result channel.
//
// Configuration macro: MAX_ARB_FIXED_PRIO_EN
//   defined   - fixed priority, the lowest index wins; no pointer state.
//   undefined - round-robin (default); the search starts at a pointer that
//               moves to gnt+1 on each result handshake.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   s_valid     [N]        per-requester beat valid
//   s_last      [N]        per-requester last beat of frame
//   s_data      [N*WIDTH]  per-requester data, requester i at [i*WIDTH +: WIDTH]
//   s_ready     [N]        per-requester beat accept (granted requester only)
//   eng_start   engine start, high for the whole granted frame
//   eng_in      [WIDTH]    engine data in (0 during gaps and outside STREAM)
//   eng_done    engine done, only honoured while waiting for the result
//   eng_max     [WIDTH]    engine maximum
//   res_valid   result valid, held until res_ready
//   res_ready   result accept
//   res_data    [WIDTH]    frame maximum
//   res_id      [IDW]      requester that owned the frame
module max_frame_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       s_valid,
  input  logic [N-1:0]       s_last,
  input  logic [N*WIDTH-1:0] s_data,
  output logic [N-1:0]       s_ready,
  output logic               eng_start,
  output logic [WIDTH-1:0]   eng_in,
  input  logic               eng_done,
  input  logic [WIDTH-1:0]   eng_max,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic [IDW-1:0]     res_id
);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StWait,
    StResult
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [IDW-1:0]   res_id_q, res_id_d;

`ifndef MAX_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   ptr_q, ptr_d;
`endif

  // Per-requester view of the flat data bus.
  logic [WIDTH-1:0] data_arr [N];

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      data_arr[i] = s_data[i*WIDTH +: WIDTH];
    end
  end

  // Granted requester's handshake signals.
  logic gnt_valid;
  logic gnt_last;

  assign gnt_valid = s_valid[gnt_q];
  assign gnt_last  = s_last[gnt_q];

  // ---------------------------------------------------------------------------
  // Winner search: scan N candidates in priority order and keep the first one
  // that is requesting.
  // ---------------------------------------------------------------------------
  logic           win_found;
  logic [IDW-1:0] win_id;

  always_comb begin
    int unsigned    cand;
    logic [IDW-1:0] cand_id;
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    cand_id   = '0;
    for (int unsigned k = 0; k < N; k++) begin
`ifdef MAX_ARB_FIXED_PRIO_EN
      cand = k;
`else
      // Start at the pointer and wrap from N-1 back to 0.
      cand = 32'(ptr_q) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
`endif
      cand_id = IDW'(cand);
      if (!win_found && s_valid[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
`ifndef MAX_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
`ifndef MAX_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
`ifndef MAX_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_d   = win_id;
          state_d = StStream;
        end
      end

      StStream: begin
        // s_ready is high for the grantee all through STREAM, so a valid
        // beat is always an accepted one.
        if (gnt_valid && gnt_last) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (eng_done) begin
          res_valid_d = 1'b1;
          res_data_d  = eng_max;
          res_id_d    = gnt_q;
          state_d     = StResult;
        end
      end

      StResult: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
`ifndef MAX_ARB_FIXED_PRIO_EN
          // The requester just served drops to lowest priority.
          if (gnt_q == IDW'(N - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = gnt_q + 1'b1;
          end
`endif
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ready   = '0;
    eng_start = 1'b0;
    eng_in    = '0;
    if (state_q == StStream) begin
      s_ready[gnt_q] = 1'b1;
      eng_start      = 1'b1;
      // A gap feeds 0, which cannot raise an unsigned maximum.
      eng_in         = gnt_valid ? data_arr[gnt_q] : '0;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_max_frame_arbiter.sv
// Testbench for max_frame_arbiter: behavioural find_max engine, table-driven
// single-requester frames, plus directed arbitration, back-pressure and
// mid-frame reset sequences.
module tb_max_frame_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDW   = 2;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       s_valid;
  logic [N-1:0]       s_last;
  logic [N*WIDTH-1:0] s_data;
  logic [N-1:0]       s_ready;
  logic               eng_start;
  logic [WIDTH-1:0]   eng_in;
  logic               eng_done;
  logic [WIDTH-1:0]   eng_max;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_data;
  logic [IDW-1:0]     res_id;

  int tests_run;
  int tests_failed;

  max_frame_arbiter #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .eng_start (eng_start),
    .eng_in    (eng_in),
    .eng_done  (eng_done),
    .eng_max   (eng_max),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural find_max engine: accumulates while start is high; done is
  // high in the first cycle after start falls.
  logic             run_q;
  logic [WIDTH-1:0] acc_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      acc_q <= '0;
    end else if (eng_start) begin
      run_q <= 1'b1;
      acc_q <= (!run_q) ? eng_in : ((eng_in > acc_q) ? eng_in : acc_q);
    end else if (run_q) begin
      run_q <= 1'b0;
    end
  end

  assign eng_done = run_q & ~eng_start;
  assign eng_max  = acc_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One frame from one requester: slots with vld=0 are gaps, the last slot
  // carries s_last.
  typedef struct packed {
    logic [1:0]  req;
    logic [2:0]  n;
    logic [5:0]  vld;
    logic [47:0] dat;
    logic [7:0]  exp_max;
  } vec_t;

  // Call in posedge+1 context; returns in posedge+1 context after the result
  // cycle (handshaked when res_ready is high).
  task automatic run_frame(input vec_t v);
    int slot;
    int cyc;
    int rdy_cnt;
    int start_cnt;
    int lat;
    logic [7:0] beat;
    slot      = 0;
    cyc       = 0;
    rdy_cnt   = 0;
    start_cnt = 0;
    while (slot < int'(v.n) && cyc < 60) begin
      beat                      = v.dat[slot*8 +: 8];
      s_valid                   = '0;
      s_last                    = '0;
      s_valid[v.req]            = v.vld[slot];
      s_last[v.req]             = (slot == int'(v.n) - 1);
      s_data[v.req*WIDTH +: 8]  = beat;
      @(negedge clk);
      if (eng_start) start_cnt++;
      if (s_ready[v.req]) begin
        rdy_cnt++;
        check("eng_in", 32'(eng_in), v.vld[slot] ? 32'(beat) : 32'd0);
        slot++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    s_valid = '0;
    s_last  = '0;
    check("frame_timeout", 32'(cyc < 60), 32'd1);
    check("s_ready_cycles", 32'(rdy_cnt), 32'(v.n));
    check("eng_start_cycles", 32'(start_cnt), 32'(v.n));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 10);
    check("res_latency", 32'(lat), 32'd2);
    check("res_data", 32'(res_data), 32'(v.exp_max));
    check("res_id", 32'(res_id), 32'(v.req));
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    check({tag, "_eng_in"}, 32'(eng_in), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_res_id"}, 32'(res_id), 32'd0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [5];

  initial begin
    int cyc;
    int got;
    int k;
    logic [3:0] pending;
    logic [3:0] rdy_snap;
    logic [1:0] exp_id;

    tests_run    = 0;
    tests_failed = 0;
    res_ready    = 1'b1;
    rst_n        = 1'b0;
    s_valid      = '0;
    s_last       = '0;
    s_data       = '0;

    // Slot 0 in the low byte of dat.
    vecs[0] = '{req: 2'd0, n: 3'd3, vld: 6'b000111, dat: 48'h00_00_00_05_09_03, exp_max: 8'h09};
    vecs[1] = '{req: 2'd2, n: 3'd1, vld: 6'b000001, dat: 48'h00_00_00_00_00_ff, exp_max: 8'hff};
    vecs[2] = '{req: 2'd1, n: 3'd4, vld: 6'b001001, dat: 48'h00_00_07_00_00_04, exp_max: 8'h07};
    vecs[3] = '{req: 2'd3, n: 3'd2, vld: 6'b000011, dat: 48'h00_00_00_00_00_00, exp_max: 8'h00};
    vecs[4] = '{req: 2'd0, n: 3'd5, vld: 6'b011111, dat: 48'h00_c7_03_c8_fe_0a, exp_max: 8'hfe};

    #1;
    check_outputs_zero("reset");
    do_reset();

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i]);
    end

    // All four request together with single-beat frames.
    do_reset();
    pending = 4'b1111;
    s_last  = 4'b1111;
    s_data  = 32'h13_12_11_10;
    got     = 0;
    cyc     = 0;
    while (got < 4 && cyc < 80) begin
      s_valid = pending;
      @(negedge clk);
      if (res_valid) begin
`ifdef MAX_ARB_FIXED_PRIO_EN
        exp_id = 2'd0;
`else
        exp_id = 2'(got);
`endif
        check("arb_res_id", 32'(res_id), 32'(exp_id));
        check("arb_res_data", 32'(res_data), 32'h10 + 32'(exp_id));
        got++;
      end
      rdy_snap = s_ready;
      @(posedge clk);
      #1;
`ifdef MAX_ARB_FIXED_PRIO_EN
      pending = (pending & ~rdy_snap) | 4'b0001;
`else
      pending = pending & ~rdy_snap;
`endif
      cyc++;
    end
    s_valid = '0;
    s_last  = '0;
    check("arb_results", 32'(got), 32'd4);

    // Result back-pressure with another requester waiting.
    do_reset();
    res_ready = 1'b0;
    run_frame('{req: 2'd1, n: 3'd2, vld: 6'b000011, dat: 48'h06_05, exp_max: 8'h06});
    s_valid[2]         = 1'b1;
    s_last[2]          = 1'b1;
    s_data[2*WIDTH +: 8] = 8'h33;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_res_valid", 32'(res_valid), 32'd1);
      check("stall_res_data", 32'(res_data), 32'h06);
      check("stall_res_id", 32'(res_id), 32'd1);
      check("stall_no_grant", 32'({s_ready, eng_start}), 32'd0);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!s_ready[2] && k < 10);
    check("stall_then_grant", 32'(s_ready[2]), 32'd1);
    @(posedge clk);
    #1;
    s_valid = '0;
    s_last  = '0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!res_valid && k < 10);
    check("stall_next_id", 32'(res_id), 32'd2);
    check("stall_next_data", 32'(res_data), 32'h33);
    @(posedge clk);
    #1;

    // Reset in the middle of a req3 frame, then a fresh req3 frame.
    s_valid[3]           = 1'b1;
    s_last[3]            = 1'b0;
    s_data[3*WIDTH +: 8] = 8'h50;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!s_ready[3] && k < 10);
    check("mid_grant", 32'(s_ready[3]), 32'd1);
    @(posedge clk);
    #1;
    s_data[3*WIDTH +: 8] = 8'h60;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    s_valid = '0;
    s_last  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame('{req: 2'd3, n: 3'd2, vld: 6'b000011, dat: 48'h03_08, exp_max: 8'h08});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
